// File: rtl/uart_chunk_pkg.sv
// Shared definitions for the UART chunk path (arbiter and chunker).
// Holds the arbiter state encoding and the default chunk geometry.
// No logic lives here.
package uart_chunk_pkg;

  localparam int DEF_BUFFER_BYTE_SIZE  = 3;
  localparam int DEF_BUFFER_INDEX_SIZE = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request bit at or above rr_ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_priority_picker #(
  parameter int NUM_REQ = 2,
  parameter int GW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_mask,
  input  logic [GW-1:0]      rr_ptr,
  output logic               any,
  output logic [GW-1:0]      idx
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [GW:0]          off;
  logic [GW:0]          sum;

  // Rotate the mask so rr_ptr sits at bit 0, find the lowest set bit, then
  // map that offset back to an absolute requester index.
  always_comb begin
    dbl = {req_mask, req_mask} >> rr_ptr;
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (dbl[i]) off = (GW+1)'(i);
    end
    sum = {1'b0, rr_ptr} + off;
    if (sum >= (GW+1)'(NUM_REQ)) sum = sum - (GW+1)'(NUM_REQ);
    any = |req_mask;
    idx = sum[GW-1:0];
  end

endmodule

// File: rtl/uart_tx_chunk_arbiter.sv
// Shares one UART chunker between NUM_REQ producers, round-robin, one chunk at a time.
// Latency: ack/chunk_ready one cycle after a request is seen idle; done one cycle after last byte.
// Backpressure: requesters hold req_valid until req_ack; new grants wait until the chunk completes.
module uart_tx_chunk_arbiter
  import uart_chunk_pkg::*;
#(
  parameter int NUM_REQ           = 2,
  parameter int BUFFER_BYTE_SIZE  = DEF_BUFFER_BYTE_SIZE,
  parameter int BUFFER_INDEX_SIZE = DEF_BUFFER_INDEX_SIZE
) (
  input  logic                                  CLK,
  input  logic                                  RST_N,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ*BUFFER_BYTE_SIZE*8-1:0] req_bytes,
  input  logic [NUM_REQ*BUFFER_INDEX_SIZE-1:0]  req_size,
  output logic [NUM_REQ-1:0]                    req_ack,
  output logic [NUM_REQ-1:0]                    req_done,
  input  logic                                  is_tx_done,
  output logic                                  chunk_ready,
  output logic [BUFFER_INDEX_SIZE-1:0]          chunk_byte_size,
  output logic [BUFFER_BYTE_SIZE*8-1:0]         chunk_bytes,
  output logic                                  busy,
  output logic [$clog2(NUM_REQ)-1:0]            grant
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = BUFFER_BYTE_SIZE * 8;
  localparam int IW = BUFFER_INDEX_SIZE;
  localparam logic [IW-1:0]      CAP     = IW'(BUFFER_BYTE_SIZE);
  localparam logic [NUM_REQ-1:0] REQ_ONE = NUM_REQ'(1);

  arb_state_e      state_q;
  arb_state_e      state_d;
  logic [GW-1:0]   rr_ptr;
  logic [IW-1:0]   sent_cnt;
  logic [IW-1:0]   eff_size;

  logic            pick_any;
  logic [GW-1:0]   pick_idx;
  logic [CW-1:0]   sel_bytes;
  logic [IW-1:0]   sel_size;
  logic [IW-1:0]   pick_eff;
  logic            last_byte;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_picker (
    .req_mask (req_valid),
    .rr_ptr   (rr_ptr),
    .any      (pick_any),
    .idx      (pick_idx)
  );

  // Select the picked requester's slice and clamp its size to the buffer capacity.
  always_comb begin
    sel_bytes = '0;
    sel_size  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == GW'(i)) begin
        sel_bytes = req_bytes[i*CW +: CW];
        sel_size  = req_size[i*IW +: IW];
      end
    end
    pick_eff  = (sel_size > CAP) ? CAP : sel_size;
    last_byte = is_tx_done && (sent_cnt == eff_size - IW'(1));
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; a zero-length chunk skips straight to completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_any) state_d = (pick_eff == '0) ? ST_DONE : ST_LOAD;
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: if (last_byte) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the granted chunk, count sent bytes and drive the registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_ptr          <= '0;
      grant           <= '0;
      sent_cnt        <= '0;
      eff_size        <= '0;
      chunk_ready     <= 1'b0;
      chunk_byte_size <= '0;
      chunk_bytes     <= '0;
      req_ack         <= '0;
      req_done        <= '0;
      busy            <= 1'b0;
    end else begin
      chunk_ready <= 1'b0;
      req_ack     <= '0;
      req_done    <= '0;
      busy        <= (state_d != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant       <= pick_idx;
            chunk_bytes <= sel_bytes;
            eff_size    <= pick_eff;
            req_ack     <= REQ_ONE << pick_idx;
            if (pick_eff == '0) begin
              req_done <= REQ_ONE << pick_idx;
            end else begin
              chunk_byte_size <= pick_eff;
              chunk_ready     <= 1'b1;
            end
          end
        end
        ST_LOAD: sent_cnt <= '0;
        ST_SEND: begin
          if (is_tx_done) sent_cnt <= sent_cnt + IW'(1);
          if (last_byte)  req_done <= REQ_ONE << grant;
        end
        ST_DONE: begin
          rr_ptr          <= (grant == GW'(NUM_REQ - 1)) ? '0 : grant + GW'(1);
          chunk_byte_size <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_chunk_arbiter.sv
// Self-checking bench for uart_tx_chunk_arbiter: directed scenarios plus random traffic.
// Expected grants come from a round-robin model over the request mask.
// Outputs are sampled 1 ns after each rising edge.
module tb_uart_tx_chunk_arbiter;

  localparam int NR = 2;
  localparam int BB = 3;
  localparam int IW = 32;
  localparam int GW = 1;
  localparam int CW = BB * 8;

  logic                 CLK;
  logic                 RST_N;
  logic [NR-1:0]        req_valid;
  logic [NR*CW-1:0]     req_bytes;
  logic [NR*IW-1:0]     req_size;
  logic [NR-1:0]        req_ack;
  logic [NR-1:0]        req_done;
  logic                 is_tx_done;
  logic                 chunk_ready;
  logic [IW-1:0]        chunk_byte_size;
  logic [CW-1:0]        chunk_bytes;
  logic                 busy;
  logic [GW-1:0]        grant;

  int vectors     = 0;
  int miscompares = 0;
  int m_rr        = 0;

  uart_tx_chunk_arbiter #(
    .NUM_REQ           (NR),
    .BUFFER_BYTE_SIZE  (BB),
    .BUFFER_INDEX_SIZE (IW)
  ) dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .req_valid       (req_valid),
    .req_bytes       (req_bytes),
    .req_size        (req_size),
    .req_ack         (req_ack),
    .req_done        (req_done),
    .is_tx_done      (is_tx_done),
    .chunk_ready     (chunk_ready),
    .chunk_byte_size (chunk_byte_size),
    .chunk_bytes     (chunk_bytes),
    .busy            (busy),
    .grant           (grant)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // First requester at or after the round-robin pointer, wrapping.
  function automatic int model_pick(input logic [NR-1:0] mask, input int rr);
    for (int i = 0; i < NR; i++) begin
      int j;
      j = (rr + i) % NR;
      if (mask[j]) return j;
    end
    return -1;
  endfunction

  function automatic int model_eff(input logic [IW-1:0] sz);
    if (sz > IW'(BB)) return BB;
    return int'(sz);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    is_tx_done = 1'b1;
    #12;
    vectors++;
    if ({chunk_ready, req_ack, req_done, busy} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 000000", {chunk_ready, req_ack, req_done, busy});
    end
    vectors++;
    if (chunk_byte_size !== '0 || chunk_bytes !== '0 || grant !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got size=%0h bytes=%0h grant=%0d want 0", chunk_byte_size, chunk_bytes, grant);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    tick();
    is_tx_done = 1'b0;
    vectors++;
    if ({busy, req_done, chunk_ready} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_stale_pulse: got %b want 0000", {busy, req_done, chunk_ready});
    end
    m_rr = 0;
  endtask

  task automatic test_single();
    int g;
    req_bytes[CW-1:0] = 24'h414243;
    req_size[IW-1:0]  = 32'd3;
    req_valid         = 2'b01;
    g = model_pick(2'b01, m_rr);
    tick();
    vectors++;
    if ({chunk_ready, req_ack, req_done, busy} !== 6'b1_01_00_1) begin
      miscompares++;
      $display("FAIL single_load_ctrl: got %b want 101001", {chunk_ready, req_ack, req_done, busy});
    end
    vectors++;
    if (chunk_byte_size !== 32'd3 || chunk_bytes !== 24'h414243 || grant !== GW'(g)) begin
      miscompares++;
      $display("FAIL single_load_data: got size=%0d bytes=%0h grant=%0d want 3 414243 %0d", chunk_byte_size, chunk_bytes, grant, g);
    end
    req_valid = 2'b00;
    tick();
    vectors++;
    if ({chunk_ready, req_ack} !== 3'b000) begin
      miscompares++;
      $display("FAIL single_one_pulse: got %b want 000", {chunk_ready, req_ack});
    end
    for (int b = 0; b < 3; b++) begin
      tick();
      is_tx_done = 1'b1;
      tick();
      is_tx_done = 1'b0;
      if (b < 2) begin
        vectors++;
        if (req_done !== 2'b00 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL single_early_done: byte %0d got done=%b busy=%b want 00 1", b, req_done, busy);
        end
      end
    end
    vectors++;
    if (req_done !== 2'b01 || req_ack !== 2'b00 || chunk_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done: got done=%b ack=%b rdy=%b want 01 00 0", req_done, req_ack, chunk_ready);
    end
    m_rr = (g + 1) % NR;
    tick();
    vectors++;
    if (busy !== 1'b0 || req_done !== 2'b00 || chunk_byte_size !== '0) begin
      miscompares++;
      $display("FAIL single_idle: got busy=%b done=%b size=%0d want 0 00 0", busy, req_done, chunk_byte_size);
    end
  endtask

  task automatic test_simultaneous();
    int g;
    int prev;
    prev = -1;
    req_bytes = {24'hB2B1B0, 24'hA2A1A0};
    req_size  = {32'd1, 32'd1};
    req_valid = 2'b11;
    for (int r = 0; r < 4; r++) begin
      g = model_pick(2'b11, m_rr);
      tick();
      vectors++;
      if (grant !== GW'(g) || g == prev || req_ack !== (2'b01 << g) || chunk_bytes !== req_bytes[g*CW +: CW]) begin
        miscompares++;
        $display("FAIL simul_grant: round %0d got grant=%0d ack=%b bytes=%0h want %0d", r, grant, req_ack, chunk_bytes, g);
      end
      tick();
      is_tx_done = 1'b1;
      tick();
      is_tx_done = 1'b0;
      vectors++;
      if (req_done !== (2'b01 << g)) begin
        miscompares++;
        $display("FAIL simul_done: round %0d got %b want %b", r, req_done, 2'b01 << g);
      end
      m_rr = (g + 1) % NR;
      prev = g;
      tick();
    end
    req_valid = 2'b00;
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_zero_size();
    req_size[IW-1:0] = 32'd0;
    req_valid        = 2'b01;
    tick();
    req_valid = 2'b00;
    vectors++;
    if ({chunk_ready, req_ack, req_done, busy} !== 6'b0_01_01_1) begin
      miscompares++;
      $display("FAIL zero_done_cycle: got %b want 001011", {chunk_ready, req_ack, req_done, busy});
    end
    m_rr = 1;
    tick();
    vectors++;
    if ({chunk_ready, req_ack, req_done, busy} !== 6'b0) begin
      miscompares++;
      $display("FAIL zero_back_idle: got %b want 000000", {chunk_ready, req_ack, req_done, busy});
    end
  endtask

  task automatic test_oversize();
    req_bytes[CW +: CW] = 24'h665544;
    req_size[IW +: IW]  = 32'd7;
    req_valid           = 2'b10;
    tick();
    req_valid = 2'b00;
    vectors++;
    if (chunk_byte_size !== 32'd3 || chunk_bytes !== 24'h665544 || grant !== 1'b1) begin
      miscompares++;
      $display("FAIL over_clamp: got size=%0d bytes=%0h grant=%0d want 3 665544 1", chunk_byte_size, chunk_bytes, grant);
    end
    tick();
    for (int b = 0; b < 3; b++) begin
      is_tx_done = 1'b1;
      tick();
      is_tx_done = 1'b0;
      if (b < 2) begin
        vectors++;
        if (req_done !== 2'b00) begin
          miscompares++;
          $display("FAIL over_early_done: byte %0d got %b want 00", b, req_done);
        end
      end
    end
    vectors++;
    if (req_done !== 2'b10) begin
      miscompares++;
      $display("FAIL over_done: got %b want 10", req_done);
    end
    m_rr = 0;
    tick();
  endtask

  task automatic test_stray();
    is_tx_done = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      vectors++;
      if (busy !== 1'b0 || req_done !== 2'b00) begin
        miscompares++;
        $display("FAIL stray_idle: pulse %0d got busy=%b done=%b want 0 00", s, busy, req_done);
      end
    end
    is_tx_done       = 1'b0;
    req_bytes[CW-1:0] = 24'h00BEEF;
    req_size[IW-1:0]  = 32'd2;
    req_valid         = 2'b01;
    tick();
    req_valid  = 2'b00;
    is_tx_done = 1'b1;
    tick();
    is_tx_done = 1'b0;
    tick();
    is_tx_done = 1'b1;
    tick();
    is_tx_done = 1'b0;
    vectors++;
    if (req_done !== 2'b00 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL stray_counted: got done=%b busy=%b want 00 1", req_done, busy);
    end
    is_tx_done = 1'b1;
    tick();
    is_tx_done = 1'b0;
    vectors++;
    if (req_done !== 2'b01) begin
      miscompares++;
      $display("FAIL stray_done: got %b want 01", req_done);
    end
    m_rr = 1;
    tick();
  endtask

  task automatic test_random();
    logic [NR-1:0] pend;
    pend = '0;
    for (int t = 0; t < 40; t++) begin
      int            g;
      int            eff;
      logic [CW-1:0] exp_bytes;
      logic [NR-1:0] oh;
      logic [IW-1:0] sz;
      is_tx_done = 1'($urandom_range(0, 1));
      pend = pend | NR'($urandom_range(0, (1 << NR) - 1));
      if (pend == '0) pend[$urandom_range(0, NR - 1)] = 1'b1;
      req_valid = pend;
      for (int i = 0; i < NR; i++) begin
        req_bytes[i*CW +: CW] = CW'($urandom);
        case ($urandom_range(0, 5))
          0:       sz = '0;
          1:       sz = $urandom;
          default: sz = IW'($urandom_range(1, 7));
        endcase
        req_size[i*IW +: IW] = sz;
      end
      g         = model_pick(pend, m_rr);
      eff       = model_eff(req_size[g*IW +: IW]);
      exp_bytes = req_bytes[g*CW +: CW];
      oh        = NR'(1) << g;
      tick();
      is_tx_done = 1'b0;
      pend       = pend & ~oh;
      req_valid  = pend;
      vectors++;
      if (grant !== GW'(g) || req_ack !== oh || busy !== 1'b1 || chunk_ready !== (eff != 0) || req_done !== ((eff == 0) ? oh : '0)) begin
        miscompares++;
        $display("FAIL rand_grant: txn %0d got g=%0d ack=%b done=%b rdy=%b want g=%0d eff=%0d", t, grant, req_ack, req_done, chunk_ready, g, eff);
      end
      req_bytes = (NR*CW)'({$urandom, $urandom});
      req_size  = {$urandom, $urandom};
      if (eff != 0) begin
        vectors++;
        if (chunk_byte_size !== IW'(eff) || chunk_bytes !== exp_bytes) begin
          miscompares++;
          $display("FAIL rand_load: txn %0d got size=%0d bytes=%0h want %0d %0h", t, chunk_byte_size, chunk_bytes, eff, exp_bytes);
        end
        is_tx_done = 1'($urandom_range(0, 1));
        tick();
        is_tx_done = 1'b0;
        for (int b = 0; b < eff; b++) begin
          for (int w = $urandom_range(0, 2); w > 0; w--) tick();
          is_tx_done = 1'b1;
          tick();
          is_tx_done = 1'b0;
          if (b < eff - 1) begin
            vectors++;
            if (req_done !== '0 || req_ack !== '0 || chunk_byte_size !== IW'(eff) || chunk_bytes !== exp_bytes) begin
              miscompares++;
              $display("FAIL rand_send: txn %0d byte %0d got done=%b size=%0d bytes=%0h", t, b, req_done, chunk_byte_size, chunk_bytes);
            end
          end
        end
        vectors++;
        if (req_done !== oh) begin
          miscompares++;
          $display("FAIL rand_done: txn %0d got %b want %b", t, req_done, oh);
        end
      end
      m_rr = (g + 1) % NR;
      tick();
      vectors++;
      if (busy !== 1'b0 || chunk_byte_size !== '0 || req_done !== '0) begin
        miscompares++;
        $display("FAIL rand_idle: txn %0d got busy=%b size=%0d done=%b", t, busy, chunk_byte_size, req_done);
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_in_send();
    int g;
    req_size[IW-1:0] = 32'd0;
    req_valid        = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    req_bytes[CW +: CW] = 24'hC3C2C1;
    req_size[IW +: IW]  = 32'd3;
    req_valid           = 2'b10;
    tick();
    req_valid = 2'b00;
    tick();
    is_tx_done = 1'b1;
    tick();
    is_tx_done = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    vectors++;
    if ({chunk_ready, req_ack, req_done, busy, grant} !== 7'b0 || chunk_byte_size !== '0 || chunk_bytes !== '0) begin
      miscompares++;
      $display("FAIL rst_send_outputs: got ctrl=%b size=%0d bytes=%0h want 0", {chunk_ready, req_ack, req_done, busy, grant}, chunk_byte_size, chunk_bytes);
    end
    m_rr = 0;
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    is_tx_done = 1'b1;
    tick();
    is_tx_done = 1'b0;
    vectors++;
    if (req_done !== 2'b00 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_send_no_done: got done=%b busy=%b want 00 0", req_done, busy);
    end
    req_size  = {32'd2, 32'd2};
    req_valid = 2'b11;
    g = model_pick(2'b11, m_rr);
    tick();
    req_valid = 2'b00;
    vectors++;
    if (grant !== GW'(g) || req_ack !== (2'b01 << g) || chunk_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_send_regrant: got grant=%0d ack=%b rdy=%b want %0d", grant, req_ack, chunk_ready, g);
    end
    tick();
    for (int b = 0; b < 2; b++) begin
      is_tx_done = 1'b1;
      tick();
      is_tx_done = 1'b0;
    end
    vectors++;
    if (req_done !== (2'b01 << g)) begin
      miscompares++;
      $display("FAIL rst_send_after: got %b want %b", req_done, 2'b01 << g);
    end
    tick();
  endtask

  initial begin
    RST_N      = 1'b0;
    req_valid  = '0;
    req_bytes  = '0;
    req_size   = '0;
    is_tx_done = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_zero_size();
    test_oversize();
    test_stray();
    test_random();
    test_reset_in_send();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_chunk_arbiter.md
# uart_tx_chunk_arbiter

Shares one `uart_tx_chunker` instance between `NUM_REQ` independent chunk producers, such as the periodic status sender and the RX echo path. Requests are granted round-robin, and one granted chunk is loaded into the chunker at a time. The block counts `uart_tx` byte-done pulses to detect chunk completion, then acknowledges the requester. It sits between the producers and the chunker's `is_chunk_ready` / `chunk_byte_size` / `chunk_bytes` inputs.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters; must be ≥2.
- `BUFFER_BYTE_SIZE`, 3: chunk capacity in bytes; must match the chunker.
- `BUFFER_INDEX_SIZE`, 32: width of the size fields.

Ports:
- `CLK` in 1: system clock (100 MHz).
- `RST_N` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: bit i is requester i's request; held high until `req_ack[i]`.
- `req_bytes` in `NUM_REQ*BUFFER_BYTE_SIZE*8`: requester i's chunk at slice i; byte 0 is in the LSBs and is sent first.
- `req_size` in `NUM_REQ*BUFFER_INDEX_SIZE`: requester i's byte count at slice i.
- `req_ack` out `NUM_REQ`: one-cycle one-hot pulse when the request is accepted.
- `req_done` out `NUM_REQ`: one-cycle one-hot pulse when the last byte has been sent.
- `is_tx_done` in 1: `uart_tx` `o_Tx_Done`, one pulse per byte.
- `chunk_ready` out 1: to chunker `is_chunk_ready`.
- `chunk_byte_size` out `BUFFER_INDEX_SIZE`: to chunker.
- `chunk_bytes` out `BUFFER_BYTE_SIZE*8`: to chunker.
- `busy` out 1: high whenever state ≠ IDLE.
- `grant` out `$clog2(NUM_REQ)`: index of the current or last granted requester.

## Operation
States are IDLE, LOAD, SEND and DONE.

- **IDLE**
  - If any `req_valid` bit is set, pick the first set bit searching from `rr_ptr` upward, wrapping modulo `NUM_REQ`.
  - Register `grant`, `chunk_bytes` (the granted slice) and `eff_size = min(req_size, BUFFER_BYTE_SIZE)`.
  - If `eff_size` = 0, go to DONE: no chunk is issued, and `req_ack` and `req_done` pulse together in the DONE cycle.
  - Otherwise, set `chunk_byte_size` ← `eff_size` and go to LOAD.
- **LOAD** (exactly 1 cycle)
  - `chunk_ready` = 1 and `req_ack[grant]` = 1.
  - Clear `sent_cnt`. Go to SEND.
- **SEND**
  - Each `is_tx_done` pulse increments `sent_cnt`.
  - On a pulse while `sent_cnt` = `eff_size`−1, go to DONE.
  - `chunk_bytes` and `chunk_byte_size` stay stable throughout.
- **DONE** (1 cycle)
  - `req_done[grant]` = 1.
  - Set `rr_ptr` ← (`grant`+1) mod `NUM_REQ`, `chunk_byte_size` ← 0, and go to IDLE.
- **Ignored pulses:** `is_tx_done` outside SEND is ignored, including stale pulses after reset.
- **Changing request data:** `req_valid`, `req_bytes` and `req_size` changes after capture have no effect on the chunk in flight.
- **Re-requesting:** a requester still asserting `req_valid` after its `req_done` is treated as a new request. Round-robin still lets the other requesters go first.

## Timing
- **Reset values:** on `RST_N` low, asynchronously:
  - state = IDLE, `rr_ptr` = 0, `grant` = 0, `sent_cnt` = 0;
  - `chunk_ready` = 0, `chunk_byte_size` = 0, `chunk_bytes` = 0;
  - `req_ack` = 0, `req_done` = 0, `busy` = 0.
- **Reset mid-operation:** reset in LOAD or SEND abandons the chunk and produces no `req_done`. The UART byte in flight completes, and its done pulse is ignored.
- **Request latency:** `req_valid` sampled high in IDLE at edge k gives `chunk_ready` and `req_ack` high during cycle k+1 only.
- **Completion latency:** the Nth `is_tx_done`, sampled at edge m, gives `req_done` high during cycle m+1. IDLE follows at m+2.
- **Minimum gap:** back-to-back grants are separated by at least one IDLE cycle.
- **Registered outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.
- **Count width:** `sent_cnt` is `BUFFER_INDEX_SIZE` bits wide, and the comparison is done at that width.

## Structure
- **Package `uart_chunk_pkg`:** state encoding constants (IDLE=0, LOAD=1, SEND=2, DONE=3) and the default `BUFFER_BYTE_SIZE` / `BUFFER_INDEX_SIZE` localparams, shared with `uart_tx_chunker`.
- **Sub-module `rr_priority_picker`:** combinational. Inputs are the `req_valid` mask and `rr_ptr`; outputs are `any` and the granted index. The FSM and the slice muxing stay in this module.

## Test plan
- **Single request:** `req_valid` = 01 with bytes 0x43,0x42,0x41 and size 3, then 3 `is_tx_done` pulses.
  - `chunk_ready` pulses once with size 3 and `chunk_bytes` = 0x414243.
  - `req_ack[0]` pulses once, and `req_done[0]` pulses one cycle after the 3rd done.
- **Simultaneous requests:** `req_valid` = 11 held throughout.
  - Grants alternate 0,1,0,1, with `rr_ptr` advancing after each DONE.
- **Zero size:** size 0.
  - `req_ack` and `req_done` pulse in the same cycle, `chunk_ready` never rises, and the block is back in IDLE after 2 cycles.
- **Oversize clamp:** size 7.
  - `chunk_byte_size` = 3, and DONE follows the 3rd pulse.
- **Stray pulses:** `is_tx_done` pulses while IDLE, then a size-2 request.
  - Stray pulses are not counted, and DONE follows the 2nd pulse inside SEND.
- **Reset in SEND:** `RST_N` low after 1 of 3 bytes.
  - All outputs are 0 immediately, no `req_done` is produced, and the next request is granted from `rr_ptr` = 0.
